// File: rtl/registro_cond_ctrl_pkg.sv
// Shared encodings for the registro_cond datapath and its command sequencer.
package registro_cond_ctrl_pkg;

  localparam logic [1:0] OP_SEND      = 2'd0;
  localparam logic [1:0] OP_ROTATE    = 2'd1;
  localparam logic [1:0] OP_LOAD_ONLY = 2'd2;

  localparam logic [1:0] MODO_PUSH  = 2'd0;
  localparam logic [1:0] MODO_CYCLE = 2'd1;
  localparam logic [1:0] MODO_LOAD  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // Unknown opcodes degrade to the harmless load-only command.
  function automatic logic [1:0] norm_op(input logic [1:0] op);
    case (op)
      OP_SEND:   return OP_SEND;
      OP_ROTATE: return OP_ROTATE;
      default:   return OP_LOAD_ONLY;
    endcase
  endfunction

endpackage

// File: rtl/registro_cond.sv
// Conditional register: parallel load, serial push with registered S_OUT, or rotate.
module registro_cond
  import registro_cond_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             ENB,
  input  logic             DIR,
  input  logic             S_IN,
  input  logic [1:0]       MODO,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             S_OUT
);

  // DIR=0 moves bits towards the MSB (MSB leaves first); DIR=1 towards the LSB.
  always_ff @(posedge CLK) begin
    if (ENB) begin
      case (MODO)
        MODO_PUSH: begin
          if (!DIR) begin
            S_OUT <= Q[WIDTH-1];
            Q     <= {Q[WIDTH-2:0], S_IN};
          end else begin
            S_OUT <= Q[0];
            Q     <= {S_IN, Q[WIDTH-1:1]};
          end
        end
        MODO_CYCLE: begin
          if (!DIR) begin
            Q <= {Q[WIDTH-2:0], Q[WIDTH-1]};
          end else begin
            Q <= {Q[0], Q[WIDTH-1:1]};
          end
        end
        MODO_LOAD: Q <= D;
        default:   Q <= Q;
      endcase
    end
  end

endmodule

// File: rtl/registro_cond_ctrl.sv
// Command sequencer driving one registro_cond through LOAD / PUSH / CYCLE steps.
module registro_cond_ctrl
  import registro_cond_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic             CMD_DIR,
  input  logic [CNT_W-1:0] CMD_COUNT,
  input  logic             HOLD,
  output logic [1:0]       REG_MODO,
  output logic             REG_ENB,
  output logic             REG_DIR,
  input  logic             REG_S_OUT,
  output logic             BIT_VALID,
  output logic             BIT_LAST,
  output logic             BUSY,
  output logic             DONE
);

  state_t           state_r;
  logic [1:0]       op_r;
  logic             dir_r;
  logic [CNT_W-1:0] cnt_r;
  logic             bit_valid_r;
  logic             bit_last_r;
  logic [1:0]       cmd_op_s;

  // S_OUT is qualified downstream by BIT_VALID; the controller never inspects it.
  logic [WIDTH-1:0] unused_s;
  assign unused_s = {WIDTH{REG_S_OUT}};

  assign cmd_op_s = norm_op(CMD_OP);

  // Sequencer state, latched command and serial-bit qualifiers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r     <= ST_IDLE;
      op_r        <= OP_LOAD_ONLY;
      dir_r       <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
      bit_valid_r <= 1'b0;
      bit_last_r  <= 1'b0;
    end else begin
      bit_valid_r <= 1'b0;
      bit_last_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (CMD_VALID) begin
            op_r  <= cmd_op_s;
            dir_r <= CMD_DIR;
            cnt_r <= CMD_COUNT;
            if (cmd_op_s == OP_ROTATE) begin
              state_r <= (CMD_COUNT != {CNT_W{1'b0}}) ? ST_SHIFT : ST_FIN;
            end else begin
              state_r <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          state_r <= ((op_r == OP_SEND) && (cnt_r != {CNT_W{1'b0}})) ? ST_SHIFT : ST_FIN;
        end
        ST_SHIFT: begin
          // HOLD freezes both the count and the state.
          if (!HOLD) begin
            cnt_r <= cnt_r - CNT_W'(1);
            if (op_r == OP_SEND) begin
              bit_valid_r <= 1'b1;
              bit_last_r  <= (cnt_r == CNT_W'(1));
            end
            if (cnt_r == CNT_W'(1)) begin
              state_r <= ST_FIN;
            end
          end
        end
        ST_FIN:  state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Register control and handshake decode from state and HOLD.
  always_comb begin
    REG_MODO  = MODO_LOAD;
    REG_ENB   = 1'b0;
    CMD_READY = 1'b0;
    case (state_r)
      ST_IDLE: CMD_READY = 1'b1;
      ST_LOAD: REG_ENB = 1'b1;
      ST_SHIFT: begin
        REG_ENB = ~HOLD;
        if (op_r == OP_SEND) begin
          REG_MODO = MODO_PUSH;
        end else begin
          REG_MODO = MODO_CYCLE;
        end
      end
      ST_FIN:  REG_ENB = 1'b0;
      default: REG_ENB = 1'b0;
    endcase
  end

  assign REG_DIR   = (state_r != ST_IDLE) ? dir_r : 1'b0;
  assign BUSY      = (state_r != ST_IDLE);
  assign DONE      = (state_r == ST_FIN);
  assign BIT_VALID = bit_valid_r;
  assign BIT_LAST  = bit_last_r;

endmodule

// File: tb/tb_registro_cond_ctrl.sv
// Directed bench: controller plus datapath, scoreboarded serial bits and DONE timing.
module tb_registro_cond_ctrl;
  import registro_cond_ctrl_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic             CMD_VALID = 1'b0;
  logic [1:0]       CMD_OP = 2'd2;
  logic             CMD_DIR = 1'b0;
  logic [CNT_W-1:0] CMD_COUNT = 4'd0;
  logic             HOLD = 1'b0;
  logic             S_IN = 1'b0;
  logic [WIDTH-1:0] D = 4'd0;
  logic             CMD_READY, REG_ENB, REG_DIR, REG_S_OUT;
  logic             BIT_VALID, BIT_LAST, BUSY, DONE;
  logic [1:0]       REG_MODO;
  logic [WIDTH-1:0] Q;

  registro_cond_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_DIR(CMD_DIR), .CMD_COUNT(CMD_COUNT), .HOLD(HOLD),
    .REG_MODO(REG_MODO), .REG_ENB(REG_ENB), .REG_DIR(REG_DIR), .REG_S_OUT(REG_S_OUT),
    .BIT_VALID(BIT_VALID), .BIT_LAST(BIT_LAST), .BUSY(BUSY), .DONE(DONE)
  );

  registro_cond #(.WIDTH(WIDTH)) u_reg (
    .CLK(CLK), .ENB(REG_ENB), .DIR(REG_DIR), .S_IN(S_IN), .MODO(REG_MODO),
    .D(D), .Q(Q), .S_OUT(REG_S_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic b;
    logic last;
  } bit_t;

  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  int               enb_cnt = 0;
  int               accepts = 0;
  logic             busy_prev = 1'b0;
  logic             exp_dir = 1'b0;
  logic [WIDTH-1:0] q_m = 4'd0;
  bit_t             exp_bits[$];
  int               exp_done[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge and retire scoreboard entries.
  task automatic tick();
    bit_t e;
    int   d;
    @(negedge CLK);
    cyc++;
    if (REG_ENB === 1'b1) enb_cnt++;
    if (BUSY === 1'b1 && busy_prev === 1'b0) accepts++;
    busy_prev = BUSY;
    if (BUSY === 1'b1) begin
      chk("ready_while_busy", CMD_READY, 0);
      chk("reg_dir", REG_DIR, exp_dir);
    end
    if (BIT_VALID === 1'b1) begin
      if (exp_bits.size() == 0) begin
        chk("unexpected_bit", BIT_VALID, 0);
      end else begin
        e = exp_bits.pop_front();
        chk("s_out", REG_S_OUT, e.b);
        chk("bit_last", BIT_LAST, e.last);
      end
    end else begin
      chk("bit_last_without_valid", BIT_LAST, 0);
    end
    if (DONE === 1'b1) begin
      if (exp_done.size() == 0) begin
        chk("unexpected_done", DONE, 0);
      end else begin
        d = exp_done.pop_front();
        chk("done_cycle", cyc, d);
      end
    end
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 60 && CMD_READY !== 1'b1; k++) tick();
    chk("ready_timeout", CMD_READY, 1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 60 && BUSY !== 1'b0; k++) tick();
    chk("idle_timeout", BUSY, 0);
    chk("bits_drained", exp_bits.size(), 0);
    chk("done_drained", exp_done.size(), 0);
  endtask

  // Drive one command and push its expected bits, final Q and DONE cycle.
  task automatic issue(input logic [1:0] op, input logic dir, input logic [CNT_W-1:0] cnt,
                       input logic [WIDTH-1:0] d, input logic sin, input logic keep,
                       input int hold_cycles);
    logic [1:0]       nop;
    logic [WIDTH-1:0] q;
    int               n;
    int               lat;
    bit_t             e;
    wait_ready();
    CMD_OP = op; CMD_DIR = dir; CMD_COUNT = cnt; D = d; S_IN = sin; CMD_VALID = 1'b1;
    n   = int'(cnt);
    nop = (op == 2'd0 || op == 2'd1) ? op : 2'd2;
    q   = q_m;
    if (nop == 2'd1) begin
      for (int i = 0; i < n; i++) q = dir ? {q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], q[WIDTH-1]};
      lat = n + 1;
    end else begin
      q   = d;
      lat = 2;
      if (nop == 2'd0 && n != 0) begin
        lat = n + 2;
        for (int i = 0; i < n; i++) begin
          e.b    = dir ? q[0] : q[WIDTH-1];
          e.last = (i == n - 1);
          exp_bits.push_back(e);
          q = dir ? {sin, q[WIDTH-1:1]} : {q[WIDTH-2:0], sin};
        end
      end
    end
    q_m     = q;
    exp_dir = dir;
    exp_done.push_back(cyc + lat + hold_cycles);
    tick();
    if (!keep) CMD_VALID = 1'b0;
  endtask

  initial begin
    int e0;
    int c0;
    int a0;

    tick(); tick();
    chk("rst_enb", REG_ENB, 0);
    chk("rst_modo", REG_MODO, MODO_LOAD);
    chk("rst_dir", REG_DIR, 0);
    chk("rst_bit_valid", BIT_VALID, 0);
    chk("rst_bit_last", BIT_LAST, 0);
    chk("rst_done", DONE, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_ready", CMD_READY, 1);
    RESET = 1'b0;
    tick();

    // SEND 1011 MSB-first: bits 1,0,1,1 then an all-zero register.
    e0 = enb_cnt;
    issue(OP_SEND, 1'b0, 4'd4, 4'b1011, 1'b0, 1'b0, 0);
    wait_idle();
    chk("send_q", Q, 4'b0000);
    chk("send_enb_cycles", enb_cnt - e0, 5);

    // ROTATE right by 1 and by 5 (wraps modulo WIDTH).
    issue(OP_LOAD_ONLY, 1'b0, 4'd0, 4'b0001, 1'b0, 1'b0, 0);
    wait_idle();
    issue(OP_ROTATE, 1'b1, 4'd1, 4'b0000, 1'b0, 1'b0, 0);
    wait_idle();
    chk("rot1_q", Q, 4'b1000);
    issue(OP_LOAD_ONLY, 1'b0, 4'd0, 4'b0001, 1'b0, 1'b0, 0);
    wait_idle();
    issue(OP_ROTATE, 1'b1, 4'd5, 4'b0000, 1'b0, 1'b0, 0);
    wait_idle();
    chk("rot5_q", Q, 4'b1000);

    // SEND stalled by HOLD for three cycles after the second bit.
    issue(OP_SEND, 1'b0, 4'd4, 4'b1011, 1'b0, 1'b0, 3);
    tick(); tick(); tick();
    HOLD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_enb", REG_ENB, 0);
      chk("hold_bit_valid", BIT_VALID, 0);
    end
    HOLD = 1'b0;
    wait_idle();
    chk("hold_send_q", Q, 4'b0000);

    // ROTATE by 0 never enables the register.
    issue(OP_LOAD_ONLY, 1'b0, 4'd0, 4'b0101, 1'b0, 1'b0, 0);
    wait_idle();
    e0 = enb_cnt;
    issue(OP_ROTATE, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0, 0);
    wait_idle();
    chk("rot0_enb_cycles", enb_cnt - e0, 0);
    chk("rot0_q", Q, 4'b0101);

    // LOAD_ONLY, undefined opcode, SEND of zero bits, and SEND beyond WIDTH.
    issue(OP_LOAD_ONLY, 1'b0, 4'd3, 4'hA, 1'b0, 1'b0, 0);
    wait_idle();
    chk("load_q", Q, 4'hA);
    issue(2'd3, 1'b1, 4'd7, 4'h5, 1'b0, 1'b0, 0);
    wait_idle();
    chk("op3_q", Q, 4'h5);
    issue(OP_SEND, 1'b0, 4'd0, 4'h6, 1'b1, 1'b0, 0);
    wait_idle();
    chk("send0_q", Q, 4'h6);
    issue(OP_SEND, 1'b1, 4'd6, 4'b1001, 1'b1, 1'b0, 0);
    wait_idle();
    chk("send6_q", Q, 4'b1111);

    // RESET during SHIFT (HOLD keeps the reset edge from stepping Q).
    issue(OP_SEND, 1'b0, 4'd4, 4'b1011, 1'b0, 1'b0, 0);
    tick(); tick(); tick();
    HOLD  = 1'b1;
    RESET = 1'b1;
    exp_bits.delete();
    exp_done.delete();
    tick();
    chk("midrst_busy", BUSY, 0);
    chk("midrst_ready", CMD_READY, 1);
    chk("midrst_done", DONE, 0);
    chk("midrst_enb", REG_ENB, 0);
    chk("midrst_bit_valid", BIT_VALID, 0);
    chk("midrst_q", Q, 4'b1100);
    RESET = 1'b0;
    HOLD  = 1'b0;
    q_m   = 4'b1100;
    tick();
    chk("midrst_no_done", DONE, 0);

    // CMD_VALID held high: one accept per IDLE visit, separated by FIN.
    a0 = accepts;
    c0 = cyc;
    issue(OP_SEND, 1'b0, 4'd2, 4'b1011, 1'b0, 1'b1, 0);
    wait_idle();
    chk("b2b_idle_cycle", cyc, c0 + 5);
    issue(OP_SEND, 1'b0, 4'd2, 4'b1011, 1'b0, 1'b1, 0);
    wait_idle();
    CMD_VALID = 1'b0;
    tick(); tick();
    chk("b2b_accepts", accepts - a0, 2);
    chk("b2b_q", Q, 4'b1100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/registro_cond_ctrl.md
Name: registro_cond_ctrl

Overview:
Sequencer for one `registro_cond` instance. It accepts a command over a valid/ready handshake and drives the register's MODO/ENB/DIR for the required number of cycles.
- SEND: load a word, then shift COUNT bits out on S_OUT.
- ROTATE: cycle the register COUNT positions.
- LOAD_ONLY: load a word only.
It flags serial-bit validity, supports pausing via HOLD and pulses DONE on completion. It sits between the bus-side command source and the register datapath.

Parameters:
WIDTH, 4, register width; sets the expected count range.
CNT_W, 4, width of CMD_COUNT and the internal down-counter.

Ports:
CLK  input  1  clock; all state changes on posedge
RESET  input  1  synchronous, active-high reset
CMD_VALID  input  1  command offered
CMD_READY  output  1  controller idle and able to accept a command
CMD_OP  input  2  `OP_SEND, `OP_ROTATE, `OP_LOAD_ONLY (other values treated as `OP_LOAD_ONLY)
CMD_DIR  input  1  shift/rotate direction; passed to register DIR
CMD_COUNT  input  CNT_W  number of PUSH/CYCLE steps
HOLD  input  1  pause stepping while high
REG_MODO  output  2  to register MODO (`PUSH/`CYCLE/`LOAD from definitions.v)
REG_ENB  output  1  to register ENB
REG_DIR  output  1  to register DIR
REG_S_OUT  input  1  register S_OUT
BIT_VALID  output  1  REG_S_OUT carries a valid shifted-out bit this cycle
BIT_LAST  output  1  qualifies the final BIT_VALID of a SEND
BUSY  output  1  command in progress
DONE  output  1  one-cycle completion pulse

Behaviour:
- Fixed decision: one clock, CLK; reset is RESET, synchronous and active-high.
- States: IDLE, LOAD, SHIFT, FIN. Registers hold the state, the latched op/dir, and cnt (CNT_W bits).
- Reset:
  - State goes to IDLE and cnt to 0.
  - Output values at reset: REG_ENB=0, REG_MODO=`LOAD, REG_DIR=0, BIT_VALID=0, BIT_LAST=0, DONE=0, BUSY=0, CMD_READY=1.
  - Reset mid-command abandons the command on that edge and issues no DONE.
  - The register contents are not touched by reset.
- IDLE:
  - CMD_READY=1, REG_ENB=0.
  - On an edge with CMD_VALID=1, latch op, dir and cnt=CMD_COUNT.
  - Next state for SEND or LOAD_ONLY: LOAD.
  - Next state for ROTATE: SHIFT if COUNT≠0, otherwise FIN.
- LOAD:
  - REG_ENB=1, REG_MODO=`LOAD for exactly one cycle.
  - Next state: SHIFT for SEND with cnt≠0; otherwise FIN.
- SHIFT:
  - REG_MODO=`PUSH for SEND, `CYCLE for ROTATE.
  - REG_ENB=~HOLD; cnt decrements only when REG_ENB=1.
  - Leave for FIN on the enabled edge where cnt==1.
  - HOLD freezes cnt and the state indefinitely.
- FIN: DONE=1 for one cycle, REG_ENB=0, then IDLE. CMD_READY is 0 here, so there is no back-to-back accept in FIN.
- Output decode:
  - REG_DIR = latched dir in every non-IDLE state.
  - BUSY = state≠IDLE.
  - REG_MODO/REG_ENB/CMD_READY are decoded combinationally from state and HOLD only.
- BIT_VALID / BIT_LAST:
  - Both are registered. BIT_VALID is set on every edge where a SEND PUSH is enabled, so it lines up with the register's registered S_OUT in the following cycle.
  - BIT_LAST is set on the PUSH edge where cnt==1. BIT_VALID drops while HOLD stalls.
  - They are never asserted for ROTATE or LOAD_ONLY.
- Latency from accept edge to DONE cycle:
  - SEND: COUNT+2 cycles; DONE coincides with the BIT_LAST cycle.
  - ROTATE: COUNT+1 cycles.
  - LOAD_ONLY: 2 cycles.
  - ROTATE with COUNT=0: 1 cycle.
- COUNT larger than WIDTH is legal:
  - SEND keeps shifting in the register's S_IN.
  - ROTATE wraps modulo WIDTH by nature of the datapath.
- SEND with COUNT=0 behaves as LOAD_ONLY.

Decomposition:
- definitions.v gains `OP_SEND=2'd0, `OP_ROTATE=2'd1, `OP_LOAD_ONLY=2'd2, and the state encodings `ST_IDLE..`ST_FIN. The existing `PUSH/`CYCLE/`LOAD macros are reused.
- No sub-module. The down-counter is inline.
- The bench instantiates registro_cond_ctrl plus registro_cond (WIDTH=4).

Test Plan:
- SEND, D=4'b1011, DIR=0, COUNT=4, S_IN=0 → one LOAD cycle, then 4 PUSH cycles. BIT_VALID high 4 cycles with REG_S_OUT=1,0,1,1; BIT_LAST and DONE on the 4th; Q=4'b0000 after.
- ROTATE, Q=4'b0001, DIR=1, COUNT=1 → Q=4'b1000; DONE 2 cycles after accept. With COUNT=5 → Q=4'b1000 after 5 CYCLE steps, DONE at accept+6.
- SEND as in case 1 with HOLD=1 for 3 cycles after the 2nd bit → REG_ENB=0 and BIT_VALID=0 during the hold. Remaining bits 1,1 resume; total DONE latency 9.
- ROTATE COUNT=0 → REG_ENB never asserted, DONE the cycle after accept, Q unchanged. LOAD_ONLY D=4'hA → Q=4'hA, DONE at accept+2.
- RESET asserted during SHIFT of a SEND COUNT=4 (after 2 bits) → next cycle IDLE, CMD_READY=1, no DONE, REG_ENB=0, Q holds its partially shifted value.
- CMD_VALID held high continuously → exactly one accept per IDLE visit. Two consecutive SEND commands are separated by the FIN cycle, and CMD_READY=0 throughout BUSY.
